// File: rtl/lcd_hd44780_rx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hd44780_rx
// Description : HD44780-compatible display-side receiver for the 4-bit LCD
//               bus; decodes instructions/data into a 2x40 DDRAM mirror.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hd44780_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rs,
    input  logic       i_e,
    input  logic       i_d4,
    input  logic       i_d5,
    input  logic       i_d6,
    input  logic       i_d7,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic [6:0] o_ac,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_four_bit,
    output logic       o_two_line,
    output logic       o_inc_dir,
    output logic       o_cmd_stb,
    output logic       o_wr_stb
);

    typedef enum logic [0:0] {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

    localparam int c_CELLS = 80;

    logic [SYNC_STAGES-1:0][5:0] r_sync;
    logic [5:0] w_pin, w_sync, r_prev;
    logic       w_fall, w_smp_rs;
    logic [3:0] w_smp_d;

    logic [6:0]         r_ac, w_nxt_ac;
    logic               r_disp, r_cur, r_blink, r_four, r_two, r_inc, r_cg;
    logic               w_nxt_disp, w_nxt_cur, w_nxt_blink, w_nxt_four, w_nxt_two, w_nxt_inc, w_nxt_cg;
    phase_t             r_phase, w_nxt_phase;
    logic [3:0]         r_hi, w_nxt_hi;
    logic               r_hi_rs, w_nxt_hi_rs;
    logic               r_cmd_stb, r_wr_stb, w_nxt_cmd, w_nxt_wr;
    logic [c_CELLS-1:0] r_valid;
    logic [7:0]         r_mem [c_CELLS];

    logic       w_exec, w_brs, w_we, w_clr;
    logic [7:0] w_byte;
    logic [6:0] w_widx;
    logic       w_rd_legal;
    logic [6:0] w_rd_idx;

    function automatic logic [6:0] f_idx(input logic [6:0] a);
        return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // RS and D travel through the same pipeline as E so they stay aligned with it
    assign w_pin    = {i_rs, i_d7, i_d6, i_d5, i_d4, i_e};
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_prev[0] & ~w_sync[0];
    assign w_smp_rs = r_prev[5];
    assign w_smp_d  = r_prev[4:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin};
            r_prev <= w_sync;
        end
    end

    always_comb begin
        w_nxt_ac    = r_ac;
        w_nxt_disp  = r_disp;
        w_nxt_cur   = r_cur;
        w_nxt_blink = r_blink;
        w_nxt_four  = r_four;
        w_nxt_two   = r_two;
        w_nxt_inc   = r_inc;
        w_nxt_cg    = r_cg;
        w_nxt_phase = r_phase;
        w_nxt_hi    = r_hi;
        w_nxt_hi_rs = r_hi_rs;
        w_nxt_cmd   = 1'b0;
        w_nxt_wr    = 1'b0;
        w_exec      = 1'b0;
        w_brs       = 1'b0;
        w_byte      = 8'h00;
        w_we        = 1'b0;
        w_clr       = 1'b0;
        w_widx      = f_idx(r_ac);

        if (w_fall) begin
            if (!r_four) begin
                w_exec = 1'b1;
                w_byte = {w_smp_d, 4'h0};
                w_brs  = w_smp_rs;
            end else if (r_phase == PH_HIGH) begin
                w_nxt_hi    = w_smp_d;
                w_nxt_hi_rs = w_smp_rs;
                w_nxt_phase = PH_LOW;
            end else begin
                w_exec      = 1'b1;
                w_byte      = {r_hi, w_smp_d};
                w_brs       = r_hi_rs;
                w_nxt_phase = PH_HIGH;
            end
        end

        if (w_exec) begin
            if (w_brs) begin
                if (!r_cg) begin
                    w_we     = 1'b1;
                    w_nxt_wr = 1'b1;
                    w_nxt_ac = f_step(r_ac, r_inc);
                end
            end else begin
                w_nxt_cmd = 1'b1;
                if (w_byte[7]) begin
                    w_nxt_ac = (w_byte[5:0] > 6'd39) ? {w_byte[6], 6'd0} : w_byte[6:0];
                    w_nxt_cg = 1'b0;
                end else if (w_byte[6]) begin
                    w_nxt_cg = 1'b1;
                end else if (w_byte[5]) begin
                    w_nxt_four  = ~w_byte[4];
                    w_nxt_two   = w_byte[3];
                    w_nxt_phase = PH_HIGH;
                end else if (w_byte[4]) begin
                    if (!w_byte[3]) w_nxt_ac = f_step(r_ac, w_byte[2]);
                end else if (w_byte[3]) begin
                    w_nxt_disp  = w_byte[2];
                    w_nxt_cur   = w_byte[1];
                    w_nxt_blink = w_byte[0];
                end else if (w_byte[2]) begin
                    w_nxt_inc = w_byte[1];
                end else if (w_byte[1]) begin
                    w_nxt_ac = 7'h00;
                end else if (w_byte[0]) begin
                    w_clr     = 1'b1;
                    w_nxt_ac  = 7'h00;
                    w_nxt_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac      <= 7'h00;
            r_disp    <= 1'b0;
            r_cur     <= 1'b0;
            r_blink   <= 1'b0;
            r_four    <= 1'b0;
            r_two     <= 1'b0;
            r_inc     <= 1'b1;
            r_cg      <= 1'b0;
            r_phase   <= PH_HIGH;
            r_hi      <= 4'h0;
            r_hi_rs   <= 1'b0;
            r_cmd_stb <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_valid   <= '0;
        end else begin
            r_ac      <= w_nxt_ac;
            r_disp    <= w_nxt_disp;
            r_cur     <= w_nxt_cur;
            r_blink   <= w_nxt_blink;
            r_four    <= w_nxt_four;
            r_two     <= w_nxt_two;
            r_inc     <= w_nxt_inc;
            r_cg      <= w_nxt_cg;
            r_phase   <= w_nxt_phase;
            r_hi      <= w_nxt_hi;
            r_hi_rs   <= w_nxt_hi_rs;
            r_cmd_stb <= w_nxt_cmd;
            r_wr_stb  <= w_nxt_wr;
            if (w_clr)     r_valid         <= '0;
            else if (w_we) r_valid[w_widx] <= 1'b1;
        end
    end

    // Character storage needs no reset: the valid bits decide what is visible
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_byte;
    end

    assign w_rd_legal = (i_rd_addr[5:0] < 6'd40);
    assign w_rd_idx   = w_rd_legal ? f_idx(i_rd_addr) : 7'd0;
    assign o_rd_data  = (w_rd_legal && r_valid[w_rd_idx]) ? r_mem[w_rd_idx] : 8'h20;

    assign o_ac        = r_ac;
    assign o_disp_on   = r_disp;
    assign o_cursor_on = r_cur;
    assign o_blink_on  = r_blink;
    assign o_four_bit  = r_four;
    assign o_two_line  = r_two;
    assign o_inc_dir   = r_inc;
    assign o_cmd_stb   = r_cmd_stb;
    assign o_wr_stb    = r_wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hd44780_rx
// Description : Directed bench for lcd_hd44780_rx with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_rx;

    localparam int c_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs = 1'b0;
    logic       e = 1'b0;
    logic [3:0] d = 4'h0;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] o_rd_data;
    logic [6:0] o_ac;
    logic       o_disp_on, o_cursor_on, o_blink_on, o_four_bit, o_two_line, o_inc_dir;
    logic       o_cmd_stb, o_wr_stb;

    int checks = 0;
    int failures = 0;
    int n_wr = 0;
    int n_cmd = 0;

    lcd_hd44780_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .i_rs(rs), .i_e(e),
        .i_d4(d[0]), .i_d5(d[1]), .i_d6(d[2]), .i_d7(d[3]),
        .i_rd_addr(rd_addr), .o_rd_data(o_rd_data), .o_ac(o_ac),
        .o_disp_on(o_disp_on), .o_cursor_on(o_cursor_on), .o_blink_on(o_blink_on),
        .o_four_bit(o_four_bit), .o_two_line(o_two_line), .o_inc_dir(o_inc_dir),
        .o_cmd_stb(o_cmd_stb), .o_wr_stb(o_wr_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Display model: a linear 80-cell buffer with the cursor as a cell position
    logic [7:0] m_mem [80];
    bit         m_valid [80];
    logic [6:0] m_ac;
    logic       m_disp, m_cur, m_blink, m_four, m_two, m_inc, m_cg, m_low, m_hirs;
    logic [3:0] m_hi;
    logic       exp_cmd, exp_wr;
    logic       p_e, p_rs, cap_rs;
    logic [3:0] p_d, cap_d;
    int         pend = 0;

    function automatic int ac2pos(input logic [6:0] a);
        return a[6] ? 40 + int'(a[5:0]) : int'(a[5:0]);
    endfunction

    function automatic logic [6:0] pos2ac(input int p);
        return (p < 40) ? 7'(p) : 7'(64 + p - 40);
    endfunction

    function automatic logic [7:0] m_rd(input logic [6:0] a);
        if (int'(a[5:0]) >= 40) return 8'h20;
        return m_valid[ac2pos(a)] ? m_mem[ac2pos(a)] : 8'h20;
    endfunction

    task automatic m_move(input logic up);
        int p;
        p = ac2pos(m_ac);
        p = up ? (p + 1) % 80 : (p + 79) % 80;
        m_ac = pos2ac(p);
    endtask

    task automatic m_reset();
        m_ac = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_four = 0; m_two = 0;
        m_inc = 1; m_cg = 0; m_low = 0; m_hi = 0; m_hirs = 0;
        for (int i = 0; i < 80; i++) m_valid[i] = 0;
    endtask

    task automatic m_exec(input logic brs, input logic [7:0] b);
        if (brs) begin
            if (!m_cg) begin
                m_mem[ac2pos(m_ac)] = b;
                m_valid[ac2pos(m_ac)] = 1;
                m_move(m_inc);
                exp_wr = 1;
            end
        end else begin
            exp_cmd = 1;
            if (b >= 8'h80) begin
                m_ac = (int'(b & 8'h3F) < 40) ? b[6:0] : 7'(b & 8'h40);
                m_cg = 0;
            end else if (b >= 8'h40) m_cg = 1;
            else if (b >= 8'h20) begin
                m_four = ((b & 8'h10) == 0); m_two = ((b & 8'h08) != 0); m_low = 0;
            end else if (b >= 8'h10) begin
                if ((b & 8'h08) == 0) m_move((b & 8'h04) != 0);
            end else if (b >= 8'h08) begin
                m_disp = b[2]; m_cur = b[1]; m_blink = b[0];
            end else if (b >= 8'h04) m_inc = b[1];
            else if (b >= 8'h02) m_ac = 0;
            else if (b == 8'h01) begin
                for (int i = 0; i < 80; i++) m_valid[i] = 0;
                m_ac = 0; m_inc = 1;
            end
        end
    endtask

    task automatic m_bus(input logic r, input logic [3:0] v);
        if (!m_four) m_exec(r, {v, 4'h0});
        else if (!m_low) begin m_hi = v; m_hirs = r; m_low = 1; end
        else begin m_low = 0; m_exec(m_hirs, {m_hi, v}); end
    endtask

    always @(negedge clk) begin
        exp_cmd = 0; exp_wr = 0;
        if (rst) begin
            m_reset();
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) m_bus(cap_rs, cap_d);
            end
            if (p_e && !e) begin cap_rs = p_rs; cap_d = p_d; pend = c_LAT; end
        end
        p_e = e; p_rs = rs; p_d = d;
        chk("ac", 32'(o_ac), 32'(m_ac));
        chk("disp_on", 32'(o_disp_on), 32'(m_disp));
        chk("cursor_on", 32'(o_cursor_on), 32'(m_cur));
        chk("blink_on", 32'(o_blink_on), 32'(m_blink));
        chk("four_bit", 32'(o_four_bit), 32'(m_four));
        chk("two_line", 32'(o_two_line), 32'(m_two));
        chk("inc_dir", 32'(o_inc_dir), 32'(m_inc));
        chk("cmd_stb", 32'(o_cmd_stb), 32'(exp_cmd));
        chk("wr_stb", 32'(o_wr_stb), 32'(exp_wr));
        chk("rd_data", 32'(o_rd_data), 32'(m_rd(rd_addr)));
        if (o_wr_stb === 1'b1) n_wr++;
        if (o_cmd_stb === 1'b1) n_cmd++;
    end

    task automatic nib(input logic r, input logic [3:0] v, input bit chg);
        @(posedge clk); #1 rs = r; d = v; e = 1'b1;
        repeat (2) @(posedge clk);
        #1 e = 1'b0;
        if (chg) begin rs = ~r; d = ~v; end
        repeat (6) @(posedge clk);
    endtask

    task automatic pair(input logic r, input logic [7:0] b);
        nib(r, b[7:4], 0);
        nib(r, b[3:0], 0);
    endtask

    task automatic rdlit(input logic [6:0] a, input logic [7:0] exp);
        @(posedge clk); #1 rd_addr = a;
        @(negedge clk);
        chk("rd_lit", 32'(o_rd_data), 32'(exp));
    endtask

    task automatic aclit(input logic [6:0] exp);
        @(negedge clk);
        chk("ac_lit", 32'(o_ac), 32'(exp));
    endtask

    task automatic sweep();
        for (int a = 0; a < 128; a++) begin
            @(posedge clk); #1 rd_addr = 7'(a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ac", 32'(o_ac), 32'h0);
        chk("rst_inc", 32'(o_inc_dir), 32'h1);
        chk("rst_four", 32'(o_four_bit), 32'h0);

        // 8-bit wake-up, switch to 4-bit, display on, clear
        nib(0, 4'h3, 0);
        nib(0, 4'h2, 0);
        pair(0, 8'h0F);
        pair(0, 8'h01);
        @(negedge clk);
        chk("t1_four", 32'(o_four_bit), 32'h1);
        chk("t1_blink", 32'(o_blink_on), 32'h1);
        aclit(7'h00);
        rdlit(7'h00, 8'h20);
        sweep();

        w0 = n_wr;
        pair(1, 8'h48);
        pair(1, 8'h69);
        aclit(7'h02);
        chk("t2_wrcnt", 32'(n_wr - w0), 32'd2);
        rdlit(7'h00, 8'h48);
        rdlit(7'h01, 8'h69);

        // Line wrap in both directions, clamping of illegal addresses
        pair(0, 8'hA7); pair(1, 8'h41);
        aclit(7'h40);
        rdlit(7'h27, 8'h41);
        pair(0, 8'h04); pair(0, 8'hC0); pair(1, 8'h42);
        aclit(7'h27);
        pair(0, 8'h80); pair(1, 8'h43);
        aclit(7'h67);
        pair(0, 8'h06); pair(0, 8'hE7); pair(1, 8'h44);
        aclit(7'h00);
        pair(0, 8'hB0);
        pair(0, 8'hF5);
        aclit(7'h40);
        pair(0, 8'h14); pair(0, 8'h10); pair(0, 8'h10); pair(0, 8'h18); pair(0, 8'h00);
        aclit(7'h27);
        nib(1, 4'h4, 0); nib(0, 4'h6, 0);
        rdlit(7'h27, 8'h46);
        nib(1, 4'h4, 1); nib(1, 4'h5, 1);
        rdlit(7'h40, 8'h45);
        pair(0, 8'h03);
        sweep();

        // Re-synchronise the interface width
        pair(0, 8'h33);
        nib(0, 4'h3, 0);
        nib(0, 4'h2, 0);
        pair(0, 8'h0C);
        @(negedge clk);
        chk("t4_disp", 32'(o_disp_on), 32'h1);
        chk("t4_cursor", 32'(o_cursor_on), 32'h0);
        pair(0, 8'h28);

        // Reset while a high nibble is held
        nib(1, 4'h4, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        w0 = n_wr;
        nib(0, 4'hC, 0);
        nib(0, 4'h0, 0);
        aclit(7'h40);
        chk("t5_wrcnt", 32'(n_wr - w0), 32'd0);
        rdlit(7'h40, 8'h20);

        // CGRAM-mode writes are dropped
        nib(0, 4'h2, 0);
        pair(0, 8'h0C);
        pair(0, 8'h40);
        w0 = n_wr;
        pair(1, 8'h55);
        aclit(7'h40);
        chk("t6_wrcnt", 32'(n_wr - w0), 32'd0);
        pair(0, 8'h85);
        pair(1, 8'h5A);
        rdlit(7'h05, 8'h5A);
        sweep();
        pair(0, 8'h04);
        pair(0, 8'h01);
        @(negedge clk);
        chk("clr_inc", 32'(o_inc_dir), 32'h1);
        rdlit(7'h05, 8'h20);
        sweep();

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
